board_io_ctrl: RTL and testbench
================================

# board_io_ctrl

Parametrised board I/O conditioner between FPGA pads and the Ibex demo system's general-purpose I/O. It synchronises and debounces N buttons and M switches, latches sticky button-press events for software, and drives registered LED outputs with per-LED software override and optional button masking. It optionally PWM-dims the RGB LED channels. It generalises the fixed 4-button/4-LED register stage in the board top into one reusable, width-configurable block.

## Interface
- NumBtn, 4: number of push buttons (≥1)
- NumSw, 4: number of slide switches (≥1)
- NumLed, 4: number of plain LEDs (≥1)
- NumRgb, 12: number of RGB LED channels (≥1)
- DebounceCycles, 50000: consecutive stable cycles before a debounced level changes (≥2)
- LedBtnMask, '0: bit i set → LED i forced 0 while debounced button i is held; bits with index ≥ NumBtn are ignored
- PwmWidth, 8: PWM counter/duty width (≥2)

- clk_sys_i  in  1  system clock; the block's only clock
- rst_sys_ni  in  1  asynchronous, active-low reset
- btn_i  in  NumBtn  raw button pads, asynchronous
- sw_i  in  NumSw  raw switch pads, asynchronous
- btn_o  out  NumBtn  debounced button level
- sw_o  out  NumSw  debounced switch level
- btn_press_o  out  NumBtn  sticky press event flags
- btn_press_clr_i  in  NumBtn  single-cycle clear pulses, one per flag
- led_gpo_i  in  NumLed  LED values from the GPO register
- led_ovr_en_i  in  NumLed  per-LED override enable
- led_ovr_val_i  in  NumLed  per-LED override value
- led_o  out  NumLed  LED pad drive, registered
- rgb_gpo_i  in  NumRgb  RGB channel enables from the GPO register
- rgb_duty_i  in  PwmWidth  global RGB brightness
- rgb_o  out  NumRgb  RGB pad drive, registered

## Operation
- Reset value of every output is 0, including all internal synchronisers, debounce counters, stable levels, press flags and the PWM counter.
- Debounce, per channel:
  - A 2-flop synchroniser produces `sync`.
  - `cnt` clears whenever `sync == stable`; otherwise it increments.
  - When `cnt == DebounceCycles-1` and `sync != stable`, the block loads `stable <= sync` and clears `cnt`.
  - A glitch shorter than DebounceCycles never reaches the output.
  - A switch held at 1 through reset appears at sw_o after debounce latency.
- Press flags:
  - A rising edge of btn_o[i] (stable 0→1) sets btn_press_o[i].
  - btn_press_clr_i[i] clears it.
  - If set and clear occur in the same cycle, set wins.
  - Falling edges have no effect on the flag.
- LED, per i, priority in order:
  - led_ovr_en_i[i] → led_ovr_val_i[i].
  - Else LedBtnMask[i] && btn_o[i] → 0.
  - Else led_gpo_i[i].
- RGB: see Configuration.

## Timing
- Debounce latency: a clean pad change held long enough appears on btn_o/sw_o exactly DebounceCycles+2 clock edges after the pad change. This is 2 edges for synchronisation plus DebounceCycles edges of mismatch.
- btn_press_o sets on the same edge on which btn_o rises.
- led_o and rgb_o: 1-cycle registered latency from the inputs, or from btn_o for masking.
- Press-flag clear takes effect on the edge after the pulse.
- Reset asserted mid-debounce or mid-PWM returns all state to 0 immediately. No event is generated on reset release.

## Configuration
- BOARD_IO_PWM_EN defined:
  - A free-running PwmWidth-bit counter wraps from 2^PwmWidth-1 to 0.
  - A duty register samples rgb_duty_i only on the wrap cycle, so duty updates are glitch-free; its reset value is 0.
  - rgb_o[i] = rgb_gpo_i[i] && (pwm_cnt < duty).
  - Duty 0 → always off; duty 2^PwmWidth-1 → on for 2^PwmWidth-1 of every 2^PwmWidth cycles.
- BOARD_IO_PWM_EN undefined:
  - rgb_o is rgb_gpo_i registered.
  - rgb_duty_i is ignored.
  - No counter or duty register is built.

## Structure
- board_io_pkg: default parameter constants (debounce count, PWM width) and the helper function for debounce counter width, $clog2(DebounceCycles).
- Sub-module board_io_debounce: one channel, containing the synchroniser, counter and stable level. It is instantiated NumBtn+NumSw times via generate.
- PWM counter, press flags and LED mux live in board_io_ctrl.

## Test plan
- DebounceCycles=8: btn_i[0] 0→1 held → btn_o[0] rises exactly 10 edges later; btn_press_o[0]=1 on the same edge.
- DebounceCycles=8: btn_i[1] pulses high for 7 cycles → btn_o[1] and btn_press_o[1] stay 0.
- Flag set on the same cycle as btn_press_clr_i[0] → flag remains 1; a clear one cycle later → 0 on the next edge.
- LedBtnMask=4'b0110, led_gpo_i=4'hF, button 2 held → led_o=4'hB; then led_ovr_en_i[2]=1 with led_ovr_val_i[2]=1 → led_o=4'hF.
- PWM enabled, PwmWidth=4, rgb_gpo_i=all ones, duty 4 → each rgb_o high 4 of 16 cycles; duty changed mid-period takes effect only after wrap; duty 0 → constant 0.
- Reset asserted mid-debounce count with sw_i=1 → sw_o=0 immediately; after release, sw_o rises DebounceCycles+2 edges later.

Source files
------------

// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared constants and helpers for the board I/O conditioner
package board_io_pkg;

    localparam int unsigned DefDebounceCycles = 50000;
    localparam int unsigned DefPwmWidth       = 8;

    // Counter must reach DebounceCycles-1; keep at least one bit for tiny counts.
    function automatic int unsigned deb_cnt_width(input int unsigned cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/board_io_debounce.sv
// rtl/board_io_debounce.sv - one-channel 2-flop synchroniser plus debounce counter
module board_io_debounce
    import board_io_pkg::*;
#(
    parameter int unsigned DebounceCycles = DefDebounceCycles
) (
    input  logic clk_sys_i,
    input  logic rst_sys_ni,
    input  logic pad_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned     CntW    = deb_cnt_width(DebounceCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q;
    logic            stable_q;
    logic            sync;
    logic            load;

    assign sync = sync_q[1];
    assign load = (cnt_q == CntLast) && (sync != stable_q);

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pad_i};
            if (sync == stable_q) begin
                cnt_q <= '0;
            end else if (load) begin
                stable_q <= sync;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = stable_q;
    // Early view of the 0->1 update so press flags set on the same edge as the level.
    assign rise_o  = load && sync;

endmodule

// File: rtl/board_io_ctrl.sv
// rtl/board_io_ctrl.sv - button/switch debounce, press flags, LED mux, RGB drive (BOARD_IO_PWM_EN adds PWM dimming)
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int unsigned       NumBtn         = 4,
    parameter int unsigned       NumSw          = 4,
    parameter int unsigned       NumLed         = 4,
    parameter int unsigned       NumRgb         = 12,
    parameter int unsigned       DebounceCycles = DefDebounceCycles,
    parameter logic [NumLed-1:0] LedBtnMask     = '0,
    parameter int unsigned       PwmWidth       = DefPwmWidth
) (
    input  logic                clk_sys_i,
    input  logic                rst_sys_ni,
    input  logic [NumBtn-1:0]   btn_i,
    input  logic [NumSw-1:0]    sw_i,
    output logic [NumBtn-1:0]   btn_o,
    output logic [NumSw-1:0]    sw_o,
    output logic [NumBtn-1:0]   btn_press_o,
    input  logic [NumBtn-1:0]   btn_press_clr_i,
    input  logic [NumLed-1:0]   led_gpo_i,
    input  logic [NumLed-1:0]   led_ovr_en_i,
    input  logic [NumLed-1:0]   led_ovr_val_i,
    output logic [NumLed-1:0]   led_o,
    input  logic [NumRgb-1:0]   rgb_gpo_i,
    input  logic [PwmWidth-1:0] rgb_duty_i,
    output logic [NumRgb-1:0]   rgb_o
);

    logic [NumBtn-1:0] btn_rise;
    logic [NumSw-1:0]  unused_sw_rise;
    logic [NumBtn-1:0] press_q;
    logic [NumLed-1:0] led_hold;
    logic [NumLed-1:0] led_q;
    logic [NumRgb-1:0] rgb_q;

    for (genvar i = 0; i < NumBtn; i++) begin : g_btn
        board_io_debounce #(.DebounceCycles(DebounceCycles)) u_deb (
            .clk_sys_i  (clk_sys_i),
            .rst_sys_ni (rst_sys_ni),
            .pad_i      (btn_i[i]),
            .level_o    (btn_o[i]),
            .rise_o     (btn_rise[i])
        );
    end

    for (genvar i = 0; i < NumSw; i++) begin : g_sw
        board_io_debounce #(.DebounceCycles(DebounceCycles)) u_deb (
            .clk_sys_i  (clk_sys_i),
            .rst_sys_ni (rst_sys_ni),
            .pad_i      (sw_i[i]),
            .level_o    (sw_o[i]),
            .rise_o     (unused_sw_rise[i])
        );
    end

    // LEDs beyond the button count have no button to be masked by.
    for (genvar i = 0; i < NumLed; i++) begin : g_hold
        if (i < NumBtn) begin : g_mask
            assign led_hold[i] = LedBtnMask[i] & btn_o[i];
        end else begin : g_nomask
            assign led_hold[i] = 1'b0;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            press_q <= '0;
            led_q   <= '0;
        end else begin
            press_q <= btn_rise | (press_q & ~btn_press_clr_i);
            led_q   <= (led_ovr_en_i & led_ovr_val_i) |
                       (~led_ovr_en_i & ~led_hold & led_gpo_i);
        end
    end

`ifdef BOARD_IO_PWM_EN
    logic [PwmWidth-1:0] pwm_cnt_q;
    logic [PwmWidth-1:0] duty_q;

    // Duty only moves on the wrap so a period never mixes two brightness values.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            rgb_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            if (&pwm_cnt_q) begin
                duty_q <= rgb_duty_i;
            end
            rgb_q <= rgb_gpo_i & {NumRgb{pwm_cnt_q < duty_q}};
        end
    end
`else
    logic unused_duty;
    assign unused_duty = ^rgb_duty_i;

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_gpo_i;
        end
    end
`endif

    assign btn_press_o = press_q;
    assign led_o       = led_q;
    assign rgb_o       = rgb_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb/tb_board_io_ctrl.sv - directed self-checking bench for board_io_ctrl
module tb_board_io_ctrl;

    localparam int unsigned NB  = 4;
    localparam int unsigned NS  = 4;
    localparam int unsigned NL  = 4;
    localparam int unsigned NR  = 12;
    localparam int unsigned DC  = 8;
    localparam int unsigned PW  = 4;

    logic          clk_sys = 1'b0;
    logic          rst_n   = 1'b0;
    logic [NB-1:0] btn_i   = '0;
    logic [NS-1:0] sw_i    = '0;
    logic [NB-1:0] btn_o;
    logic [NS-1:0] sw_o;
    logic [NB-1:0] btn_press_o;
    logic [NB-1:0] btn_press_clr_i = '0;
    logic [NL-1:0] led_gpo_i       = '0;
    logic [NL-1:0] led_ovr_en_i    = '0;
    logic [NL-1:0] led_ovr_val_i   = '0;
    logic [NL-1:0] led_o;
    logic [NR-1:0] rgb_gpo_i       = '0;
    logic [PW-1:0] rgb_duty_i      = '0;
    logic [NR-1:0] rgb_o;

    int checks   = 0;
    int failures = 0;

    board_io_ctrl #(
        .NumBtn         (NB),
        .NumSw          (NS),
        .NumLed         (NL),
        .NumRgb         (NR),
        .DebounceCycles (DC),
        .LedBtnMask     (4'b0110),
        .PwmWidth       (PW)
    ) dut (
        .clk_sys_i       (clk_sys),
        .rst_sys_ni      (rst_n),
        .btn_i           (btn_i),
        .sw_i            (sw_i),
        .btn_o           (btn_o),
        .sw_o            (sw_o),
        .btn_press_o     (btn_press_o),
        .btn_press_clr_i (btn_press_clr_i),
        .led_gpo_i       (led_gpo_i),
        .led_ovr_en_i    (led_ovr_en_i),
        .led_ovr_val_i   (led_ovr_val_i),
        .led_o           (led_o),
        .rgb_gpo_i       (rgb_gpo_i),
        .rgb_duty_i      (rgb_duty_i),
        .rgb_o           (rgb_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    initial begin
        int hi_a, hi_b, hi_c, hi_d;

        step(3);
        check_eq("rst_btn",   32'(btn_o), 32'h0);
        check_eq("rst_sw",    32'(sw_o), 32'h0);
        check_eq("rst_press", 32'(btn_press_o), 32'h0);
        check_eq("rst_led",   32'(led_o), 32'h0);
        check_eq("rst_rgb",   32'(rgb_o), 32'h0);
        rst_n = 1'b1;
        step(2);

        // Clean press: level and flag appear exactly DC+2 edges later.
        btn_i[0] = 1'b1;
        step(9);
        check_eq("lat_btn_e9",   32'(btn_o), 32'h0);
        check_eq("lat_press_e9", 32'(btn_press_o), 32'h0);
        step(1);
        check_eq("lat_btn_e10",   32'(btn_o), 32'h1);
        check_eq("lat_press_e10", 32'(btn_press_o), 32'h1);

        // Seven-cycle glitch is filtered out.
        btn_i[1] = 1'b1;
        step(7);
        btn_i[1] = 1'b0;
        step(20);
        check_eq("glitch_btn",   32'(btn_o), 32'h1);
        check_eq("glitch_press", 32'(btn_press_o), 32'h1);

        // Clear coinciding with the set edge loses; the following clear wins.
        btn_i[3] = 1'b1;
        step(9);
        btn_press_clr_i[3] = 1'b1;
        step(1);
        check_eq("setwins_press", 32'(btn_press_o), 32'h9);
        step(1);
        btn_press_clr_i[3] = 1'b0;
        check_eq("clr_press", 32'(btn_press_o), 32'h1);
        btn_press_clr_i[0] = 1'b1;
        step(1);
        btn_press_clr_i[0] = 1'b0;
        check_eq("clr0_press", 32'(btn_press_o), 32'h0);
        btn_i[0] = 1'b0;
        btn_i[3] = 1'b0;
        step(12);
        check_eq("fall_btn",   32'(btn_o), 32'h0);
        check_eq("fall_press", 32'(btn_press_o), 32'h0);

        // LED mux: button mask, then override.
        led_gpo_i = 4'hF;
        btn_i[2]  = 1'b1;
        step(12);
        check_eq("led_mask", 32'(led_o), 32'hB);
        led_ovr_en_i[2]  = 1'b1;
        led_ovr_val_i[2] = 1'b1;
        step(1);
        check_eq("led_ovr_on", 32'(led_o), 32'hF);
        led_ovr_en_i[0]  = 1'b1;
        led_ovr_val_i[0] = 1'b0;
        step(1);
        check_eq("led_ovr_off", 32'(led_o), 32'hE);
        led_ovr_en_i  = '0;
        led_ovr_val_i = '0;
        led_gpo_i     = 4'h7;
        step(1);
        check_eq("led_gpo_mask", 32'(led_o), 32'h3);
        btn_i[2]  = 1'b0;
        led_gpo_i = 4'h0;
        step(12);
        btn_press_clr_i = '1;
        step(1);
        btn_press_clr_i = '0;

        // Reset mid-debounce clears everything at once; switch re-qualifies afterwards.
        sw_i = 4'b0010;
        step(12);
        check_eq("sw_settle", 32'(sw_o), 32'h2);
        sw_i = 4'b0110;
        step(4);
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_sw", 32'(sw_o), 32'h0);
        step(3);
        rst_n = 1'b1;
        step(9);
        check_eq("rel_sw_e9", 32'(sw_o), 32'h0);
        step(1);
        check_eq("rel_sw_e10",   32'(sw_o), 32'h6);
        check_eq("rel_no_press", 32'(btn_press_o), 32'h0);

`ifdef BOARD_IO_PWM_EN
        rst_n      = 1'b0;
        rgb_gpo_i  = '1;
        rgb_duty_i = 4'd4;
        step(2);
        rst_n = 1'b1;
        hi_a = 0; hi_b = 0; hi_c = 0; hi_d = 0;
        for (int k = 1; k <= 96; k++) begin
            step(1);
            if (k == 16) check_eq("pwm_pre_wrap", 32'(rgb_o), 32'h0);
            if (k == 17) check_eq("pwm_first_on", 32'(rgb_o), 32'hFFF);
            if (k >= 17 && k <= 32) hi_a += int'(rgb_o == '1);
            if (k >= 33 && k <= 48) hi_b += int'(rgb_o == '1);
            if (k >= 49 && k <= 64) hi_c += int'(rgb_o == '1);
            if (k >= 65 && k <= 96) hi_d += int'(rgb_o == '1);
            if (k == 40) rgb_duty_i = 4'd8;
            if (k == 56) rgb_duty_i = 4'd0;
        end
        check_eq("pwm_duty4",      32'(hi_a), 32'd4);
        check_eq("pwm_midchange",  32'(hi_b), 32'd4);
        check_eq("pwm_duty8",      32'(hi_c), 32'd8);
        check_eq("pwm_duty0",      32'(hi_d), 32'd0);
`else
        rgb_gpo_i  = 12'hA5C;
        rgb_duty_i = '0;
        step(1);
        check_eq("rgb_pass_a", 32'(rgb_o), 32'hA5C);
        rgb_gpo_i  = 12'h3F0;
        rgb_duty_i = 4'd9;
        step(1);
        check_eq("rgb_pass_b", 32'(rgb_o), 32'h3F0);
        hi_a = 0; hi_b = 0; hi_c = 0; hi_d = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
